mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 82 ++++++++
 tb/tb_mdu.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue and held until the busy window expires.
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOp,
   input  logic        start,
   input  logic        Req,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDU_out
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1) < 4 ? 4 : $clog2(MAXC + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   res_hi, res_lo;
   logic          op_valid, accept, is_mul, signed_div;
   logic [63:0]   prod_s, prod_u, nxt;
   logic [31:0]   mag_a, mag_b, q, r, div_hi, div_lo;

   assign op_valid = MDUOp >= 4'd1 && MDUOp <= 4'd4;
   assign accept   = state == IDLE && start && !Req && op_valid;
   assign is_mul   = MDUOp == 4'd1 || MDUOp == 4'd2;
   assign MDU_out  = MDUOp == 4'd5 ? HI : MDUOp == 4'd6 ? LO : 32'd0;

   // Signed division works on magnitudes so 0x80000000 / -1 needs no special case.
   always_comb begin
      prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      prod_u     = {32'd0, A} * {32'd0, B};
      signed_div = MDUOp == 4'd3;
      mag_a      = signed_div && A[31] ? -A : A;
      mag_b      = signed_div && B[31] ? -B : B;
      q          = mag_b == 32'd0 ? 32'd0 : mag_a / mag_b;
      r          = mag_b == 32'd0 ? 32'd0 : mag_a % mag_b;
      div_lo     = signed_div && (A[31] ^ B[31]) ? -q : q;
      div_hi     = signed_div && A[31] ? -r : r;
      nxt        = MDUOp == 4'd1 ? prod_s :
                   MDUOp == 4'd2 ? prod_u :
                   B == 32'd0    ? {HI, LO} : {div_hi, div_lo};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         busy   <= 1'b0;
         HI     <= 32'd0;
         LO     <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
      end else if (state == IDLE) begin
         if (accept) begin
            {res_hi, res_lo} <= nxt;
            cnt   <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state <= BUSY;
            busy  <= 1'b1;
         end else if (!Req && MDUOp == 4'd7) begin
            HI <= A;
         end else if (!Req && MDUOp == 4'd8) begin
            LO <= A;
         end
      end else begin
         cnt <= cnt - 1'b1;
         if (cnt == CW'(1)) begin
            HI    <= res_hi;
            LO    <= res_lo;
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized self-checking bench for mdu against a longint arithmetic model.
module tb_mdu;
   logic        clk = 0, reset = 0, start = 0, Req = 0;
   logic [3:0]  MDUOp = 0;
   logic [31:0] A = 0, B = 0;
   logic        busy;
   logic [31:0] HI, LO, MDU_out;
   logic [31:0] m_hi = 0, m_lo = 0;
   int          checks = 0, errors = 0;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDUOp(MDUOp), .start(start), .Req(Req),
      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
   );

   always #5 clk = ~clk;

   task step;
      @(posedge clk);
      #1;
   endtask

   task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = $signed(a), sb = $signed(b);
      longint unsigned ua = a, ub = b;
      longint          p;
      if (op == 1) begin
         p = sa * sb;
         {m_hi, m_lo} = p[63:0];
      end else if (op == 2) begin
         {m_hi, m_lo} = ua * ub;
      end else if (op == 3 && b != 0) begin
         p = sa / sb;
         m_lo = p[31:0];
         p = sa % sb;
         m_hi = p[31:0];
      end else if (op == 4 && b != 0) begin
         m_lo = 32'(ua / ub);
         m_hi = 32'(ua % ub);
      end
   endtask

   task automatic check_hilo(input string name);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %0b want 0", name, busy); end
      checks++;
      if (HI !== m_hi) begin errors++; $display("FAIL %s HI got %h want %h", name, HI, m_hi); end
      checks++;
      if (LO !== m_lo) begin errors++; $display("FAIL %s LO got %h want %h", name, LO, m_lo); end
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      int n = (op <= 2) ? 5 : 10;
      logic [31:0] old_hi = m_hi, old_lo = m_lo;
      MDUOp = op; A = a; B = b; start = 1; Req = 0;
      step;
      start = 0; MDUOp = 0; A = $urandom; B = $urandom;
      model(op, a, b);
      for (int i = 0; i < n; i++) begin
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL %s busy cycle %0d got %0b want 1", name, i + 1, busy); end
         if (i == n / 2) begin
            checks++;
            if (HI !== old_hi || LO !== old_lo) begin
               errors++; $display("FAIL %s early HI/LO got %h/%h want %h/%h", name, HI, LO, old_hi, old_lo);
            end
         end
         step;
      end
      check_hilo(name);
   endtask

   task automatic test_reset;
      step;
      check_hilo("reset");
      #2 reset = 1;
      step;
   endtask

   task automatic test_mult;
      run_op(1, 32'hFFFFFFFE, 32'd3, "mult_neg");
      checks++;
      if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
         errors++; $display("FAIL mult_const got %h/%h want ffffffff/fffffffa", HI, LO);
      end
      run_op(2, 32'hFFFFFFFE, 32'd3, "multu");
      checks++;
      if (HI !== 32'h2 || LO !== 32'hFFFFFFFA) begin
         errors++; $display("FAIL multu_const got %h/%h want 00000002/fffffffa", HI, LO);
      end
      run_op(1, 32'h80000000, 32'h80000000, "mult_min");
   endtask

   task automatic test_div;
      run_op(3, 32'hFFFFFFF9, 32'd2, "div_neg");
      checks++;
      if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
         errors++; $display("FAIL div_const got %h/%h want ffffffff/fffffffd", HI, LO);
      end
      run_op(3, 32'h1234, 32'd0, "div_zero");
      run_op(4, 32'hDEAD, 32'd0, "divu_zero");
      run_op(3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      checks++;
      if (HI !== 32'h0 || LO !== 32'h80000000) begin
         errors++; $display("FAIL div_ovf_const got %h/%h want 00000000/80000000", HI, LO);
      end
      run_op(4, 32'hFFFFFFF9, 32'd2, "divu");
      run_op(3, 32'd7, 32'hFFFFFFFE, "div_negdiv");
   endtask

   task automatic test_mtx;
      MDUOp = 7; A = 32'h1234;
      step;
      m_hi = 32'h1234;
      MDUOp = 5;
      #1;
      check_hilo("mthi");
      checks++;
      if (MDU_out !== 32'h1234) begin errors++; $display("FAIL mfhi got %h want 00001234", MDU_out); end
      MDUOp = 8; A = 32'h5678;
      step;
      m_lo = 32'h5678;
      MDUOp = 6;
      #1;
      checks++;
      if (MDU_out !== 32'h5678) begin errors++; $display("FAIL mflo got %h want 00005678", MDU_out); end
      MDUOp = 0;
      #1;
      checks++;
      if (MDU_out !== 32'h0) begin errors++; $display("FAIL mfnone got %h want 0", MDU_out); end
      MDUOp = 8; A = 32'hBAD; Req = 1;
      step;
      MDUOp = 7;
      step;
      Req = 0; MDUOp = 0;
      check_hilo("mtx_req");
   endtask

   task automatic test_req;
      MDUOp = 1; A = 5; B = 7; start = 1; Req = 1;
      step;
      Req = 0; MDUOp = 9;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_req busy got %0b want 0", busy); end
      step;
      start = 0; MDUOp = 0;
      check_hilo("start_badop");
   endtask

   task automatic test_back_to_back;
      logic [31:0] old_hi = m_hi, old_lo = m_lo;
      MDUOp = 2; A = 32'h10001; B = 32'hFFFF0000; start = 1;
      step;
      model(2, 32'h10001, 32'hFFFF0000);
      MDUOp = 3; A = 100; B = 3;
      step;
      start = 0; MDUOp = 7; A = 32'hAAAA;
      step;
      MDUOp = 8; Req = 1;
      step;
      MDUOp = 0; Req = 0;
      checks++;
      if (busy !== 1'b1 || HI !== old_hi || LO !== old_lo) begin
         errors++; $display("FAIL b2b_mid busy/HI/LO got %0b/%h/%h want 1/%h/%h", busy, HI, LO, old_hi, old_lo);
      end
      step;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_last busy got %0b want 1", busy); end
      step;
      check_hilo("b2b");
      run_op(3, 32'd100, 32'd3, "after_b2b");
   endtask

   task automatic test_reset_mid;
      MDUOp = 4; A = 32'hFFFF; B = 32'h3; start = 1;
      step;
      start = 0; MDUOp = 0;
      step;
      step;
      #2 reset = 0;
      #1;
      m_hi = 0; m_lo = 0;
      check_hilo("reset_mid");
      step;
      #2 reset = 1;
      for (int i = 0; i < 12; i++) step;
      check_hilo("reset_nolate");
   endtask

   task automatic test_random;
      logic [3:0]  op;
      logic [31:0] a, b;
      for (int k = 0; k < 30; k++) begin
         op = 4'($urandom_range(1, 6));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 100)));
         if (op <= 4) run_op(op, a, b, "random");
         else begin
            MDUOp = op + 4'd2; A = a;
            step;
            MDUOp = 0;
            if (op == 5) m_hi = a; else m_lo = a;
            check_hilo("random_mtx");
         end
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_mtx;
      test_req;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
